// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge
//   Decodes a two-bit chip bus command each cycle and drives a local word
//   memory: write-address latch, write commit, pipelined read and halt.
//   Reads return after READ_LAT cycles; out-of-range accesses are flagged.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   read_write            command bit (msb of command)
//   write_commit          command bit (lsb of command)
//   addr_data [ADDR_W]    address or write data, meaning set by command
//   mem_result [MEM_W]    read data, held between mem_valid pulses
//   mem_valid             one-cycle pulse per completed read
//   halted                level, halt command accepted
//   dump_mem              one-cycle pulse when halted rises
//   rd_count, wr_count    saturating accepted read/write totals
//   addr_err              sticky out-of-range access flag
module mem_bus_bridge #(
  parameter int ADDR_W   = 10,
  parameter int MEM_W    = 12,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_write,
  input  logic              write_commit,
  input  logic [ADDR_W-1:0] addr_data,
  output logic [MEM_W-1:0]  mem_result,
  output logic              mem_valid,
  output logic              halted,
  output logic              dump_mem,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic              addr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;
  state_t state;

  logic [MEM_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] write_addr;

  logic cmd_wa, cmd_wc, cmd_rd, cmd_halt;
  logic rd_in_range, wr_in_range;
  logic [MEM_W-1:0] rd_data;

  // Commands only take effect in RUN; HALT swallows everything.
  assign cmd_wa   = (state == RUN) & ~read_write & ~write_commit;
  assign cmd_wc   = (state == RUN) & ~read_write &  write_commit;
  assign cmd_rd   = (state == RUN) &  read_write & ~write_commit;
  assign cmd_halt = (state == RUN) &  read_write &  write_commit;

  assign rd_in_range = {1'b0, addr_data}  < DEPTH_L;
  assign wr_in_range = {1'b0, write_addr} < DEPTH_L;

  // Array is read in the request cycle, so a commit at the previous edge
  // is already visible (read-after-write needs no bypass).
  assign rd_data = rd_in_range ? mem[addr_data[AW-1:0]] : '0;

  // Memory has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (cmd_wc && wr_in_range)
      mem[write_addr[AW-1:0]] <= MEM_W'(addr_data);
  end

  // Read pipeline: stage i holds data i cycles after the request. Data
  // registers only load behind a valid, so the last stage holds its value
  // between pulses and doubles as mem_result.
  logic [READ_LAT:1]            vld_pipe;
  logic [READ_LAT:1][MEM_W-1:0] data_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[1] <= cmd_rd;
      if (cmd_rd) data_pipe[1] <= rd_data;
      for (int i = 2; i <= READ_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  assign mem_valid  = vld_pipe[READ_LAT];
  assign mem_result = data_pipe[READ_LAT];

  // Control FSM with registered status outputs and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      halted     <= 1'b0;
      dump_mem   <= 1'b0;
      write_addr <= '0;
      rd_count   <= '0;
      wr_count   <= '0;
      addr_err   <= 1'b0;
    end else begin
      dump_mem <= 1'b0;
      case (state)
        RUN: begin
          if (cmd_halt) begin
            state    <= HALT;
            halted   <= 1'b1;
            dump_mem <= 1'b1;
          end
          if (cmd_wa) write_addr <= addr_data;
          if (cmd_wc) begin
            if (wr_count != '1) wr_count <= wr_count + 1'b1;
            if (!wr_in_range)   addr_err <= 1'b1;
          end
          if (cmd_rd) begin
            if (rd_count != '1) rd_count <= rd_count + 1'b1;
            if (!rd_in_range)   addr_err <= 1'b1;
          end
        end
        HALT: state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge. Two instances share the bus:
//   u3: DEPTH=512, READ_LAT=3, CNT_W=4 (pipelining, range, saturation, halt)
//   u1: defaults, READ_LAT=1 (single-cycle write-then-read)
module tb_mem_bus_bridge;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       read_write = 1'b0;
  logic       write_commit = 1'b0;
  logic [9:0] addr_data = '0;

  logic [11:0] res3, res1;
  logic        val3, hlt3, dmp3, err3;
  logic        val1, hlt1, dmp1, err1;
  logic [3:0]  rdc3, wrc3;
  logic [15:0] rdc1, wrc1;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_bus_bridge #(.ADDR_W(10), .MEM_W(12), .DEPTH(512), .READ_LAT(3), .CNT_W(4)) u3 (
    .clk(clk), .rst(rst), .read_write(read_write), .write_commit(write_commit),
    .addr_data(addr_data), .mem_result(res3), .mem_valid(val3), .halted(hlt3),
    .dump_mem(dmp3), .rd_count(rdc3), .wr_count(wrc3), .addr_err(err3));

  mem_bus_bridge #(.ADDR_W(10), .MEM_W(12), .DEPTH(1024), .READ_LAT(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .read_write(read_write), .write_commit(write_commit),
    .addr_data(addr_data), .mem_result(res1), .mem_valid(val1), .halted(hlt1),
    .dump_mem(dmp1), .rd_count(rdc1), .wr_count(wrc1), .addr_err(err1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one command, clock it, return 1 ns after the edge.
  task automatic cyc(input logic rw, input logic wc, input logic [9:0] ad);
    read_write   = rw;
    write_commit = wc;
    addr_data    = ad;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 10'd0);
  endtask

  task automatic wr(input logic [9:0] a, input logic [9:0] d);
    cyc(1'b0, 1'b0, a);
    cyc(1'b0, 1'b1, d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(2);
    check("rst_res3",  32'(res3), 0);
    check("rst_val3",  32'(val3), 0);
    check("rst_hlt3",  32'(hlt3), 0);
    check("rst_dmp3",  32'(dmp3), 0);
    check("rst_rdc3",  32'(rdc3), 0);
    check("rst_wrc3",  32'(wrc3), 0);
    check("rst_err3",  32'(err3), 0);
    check("rst_val1",  32'(val1), 0);
    rst = 1'b0;

    // Write 0x2A to addr 5, read back
    wr(10'd5, 10'h2A);
    cyc(1'b1, 1'b0, 10'd5);
    check("wr_rd_val1", 32'(val1), 1);
    check("wr_rd_res1", 32'(res1), 32'h02A);
    check("wr_rd_wrc1", 32'(wrc1), 1);
    check("wr_rd_rdc1", 32'(rdc1), 1);
    check("lat3_e1",    32'(val3), 0);
    idle(1);
    check("val1_pulse", 32'(val1), 0);
    check("lat3_e2",    32'(val3), 0);
    idle(1);
    check("lat3_val",   32'(val3), 1);
    check("lat3_res",   32'(res3), 32'h02A);
    check("wr_rd_wrc3", 32'(wrc3), 1);
    check("wr_rd_rdc3", 32'(rdc3), 1);
    idle(1);
    check("val3_drop",  32'(val3), 0);
    check("res3_hold",  32'(res3), 32'h02A);

    // Back-to-back reads of 1,2,3
    do_reset();
    wr(10'd1, 10'h11);
    wr(10'd2, 10'h22);
    wr(10'd3, 10'h33);
    cyc(1'b1, 1'b0, 10'd1);
    check("pipe_e1", 32'(val3), 0);
    cyc(1'b1, 1'b0, 10'd2);
    check("pipe_e2", 32'(val3), 0);
    cyc(1'b1, 1'b0, 10'd3);
    check("pipe_v1", 32'(val3), 1);
    check("pipe_d1", 32'(res3), 32'h011);
    idle(1);
    check("pipe_v2", 32'(val3), 1);
    check("pipe_d2", 32'(res3), 32'h022);
    idle(1);
    check("pipe_v3", 32'(val3), 1);
    check("pipe_d3", 32'(res3), 32'h033);
    idle(1);
    check("pipe_end", 32'(val3), 0);
    check("pipe_rdc", 32'(rdc3), 3);

    // Read right after commit to the same address, zero-extended data
    wr(10'd9, 10'h3FF);
    cyc(1'b1, 1'b0, 10'd9);
    idle(2);
    check("raw_val", 32'(val3), 1);
    check("raw_res", 32'(res3), 32'h3FF);

    // Out of range on DEPTH=512
    do_reset();
    wr(10'd88, 10'h58);
    check("oor_err0", 32'(err3), 0);
    cyc(1'b1, 1'b0, 10'd600);
    check("oor_rd_err", 32'(err3), 1);
    idle(2);
    check("oor_rd_val", 32'(val3), 1);
    check("oor_rd_res", 32'(res3), 0);
    wr(10'd600, 10'h155);
    check("oor_wrc", 32'(wrc3), 2);
    cyc(1'b1, 1'b0, 10'd88);
    idle(2);
    check("oor_alias", 32'(res3), 32'h058);
    check("oor_rdc",   32'(rdc3), 2);

    // Halt with a read in flight
    do_reset();
    wr(10'd7, 10'h77);
    cyc(1'b1, 1'b0, 10'd7);
    cyc(1'b1, 1'b1, 10'd0);
    check("halt_hlt", 32'(hlt3), 1);
    check("halt_dmp", 32'(dmp3), 1);
    check("halt_v0",  32'(val3), 0);
    cyc(1'b1, 1'b1, 10'd0);
    check("halt_dmp_once", 32'(dmp3), 0);
    check("halt_flight_v", 32'(val3), 1);
    check("halt_flight_d", 32'(res3), 32'h077);
    begin
      int pulses = 0;
      int dumps  = 0;
      wr(10'd7, 10'h11);
      if (dmp3) dumps++;
      cyc(1'b1, 1'b0, 10'd7);
      if (dmp3) dumps++;
      for (int k = 0; k < 4; k++) begin
        cyc(1'b1, 1'b1, 10'd0);
        if (val3) pulses++;
        if (dmp3) dumps++;
      end
      check("halt_no_rd",   32'(pulses), 0);
      check("halt_no_dump", 32'(dumps), 0);
    end
    check("halt_hold",  32'(hlt3), 1);
    check("halt_wrc",   32'(wrc3), 1);
    check("halt_rdc",   32'(rdc3), 1);
    do_reset();
    cyc(1'b1, 1'b0, 10'd7);
    idle(2);
    check("halt_mem", 32'(res3), 32'h077);

    // Counter saturation at 15
    do_reset();
    for (int k = 0; k < 19; k++) cyc(1'b1, 1'b0, 10'd600);
    cyc(1'b1, 1'b0, 10'd7);
    idle(2);
    check("sat_rdc", 32'(rdc3), 15);
    check("sat_res", 32'(res3), 32'h077);
    check("sat_err", 32'(err3), 1);

    // Asynchronous reset between edges with a read in flight
    cyc(1'b1, 1'b0, 10'd7);
    cyc(1'b1, 1'b1, 10'd0);
    check("ar_pre_hlt", 32'(hlt3), 1);
    #2 rst = 1'b1;
    #1;
    check("ar_res", 32'(res3), 0);
    check("ar_val", 32'(val3), 0);
    check("ar_hlt", 32'(hlt3), 0);
    check("ar_dmp", 32'(dmp3), 0);
    check("ar_rdc", 32'(rdc3), 0);
    check("ar_wrc", 32'(wrc3), 0);
    check("ar_err", 32'(err3), 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int pulses = 0;
      for (int k = 0; k < 5; k++) begin
        idle(1);
        if (val3) pulses++;
      end
      check("ar_no_val", 32'(pulses), 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
